spill_slot_manager: RTL

- Successor spill-slot allocator for the SM spill buffer in LDS.
- Serves NWARPS warps from one circular slot ring. Every allocation is contiguous; an allocation that would straddle the ring end is padded to slot 0.
- Frees are by warp and may arrive in any order. Slots are reclaimed in allocation order through an in-order record FIFO.
- When LDS cannot hold a request, the block answers "off-chip". The warp scheduler then routes that spill to device memory.

---
 rtl/spill_pkg.sv | 46 ++++
 rtl/spill_rec_fifo.sv | 87 ++++++++
 rtl/spill_slot_manager.sv | 125 ++++++++++++
 3 files changed

// File: rtl/spill_pkg.sv
// Shared types and helpers for the LDS spill-slot allocator: record layout and
// the contiguous-fit calculation used on every allocation request.
package spill_pkg;

    localparam int DEF_SLOTS     = 256;
    localparam int DEF_MAX_N     = 16;
    localparam int DEF_NWARPS    = 32;
    localparam int DEF_REC_DEPTH = 16;

    // Field widths are generous so any sensible SLOTS/MAX_N/NWARPS fits.
    localparam int REC_WID_W = 8;
    localparam int REC_N_W   = 8;
    localparam int REC_PAD_W = 16;

    typedef struct packed {
        logic [REC_WID_W-1:0] wid;
        logic [REC_N_W-1:0]   n;
        logic [REC_PAD_W-1:0] pad;
        logic                 done;
    } rec_t;

    typedef struct packed {
        logic                 fits;
        logic [REC_PAD_W-1:0] pad;
        logic [REC_PAD_W-1:0] base;
    } fit_t;

    function automatic fit_t fit_calc(input int unsigned head, input int unsigned n,
                                      input int unsigned used, input int unsigned slots);
        fit_t        r;
        int unsigned pad_v;
        int unsigned base_v;
        if (head + n <= slots) begin
            pad_v  = 0;
            base_v = head;
        end else begin
            pad_v  = slots - head;
            base_v = 0;
        end
        r.fits = (used + pad_v + n <= slots);
        r.pad  = REC_PAD_W'(pad_v);
        r.base = REC_PAD_W'(base_v);
        return r;
    endfunction

endpackage

// File: rtl/spill_rec_fifo.sv
// In-order allocation record FIFO with per-entry done bits and an oldest-first
// warp-id search starting at the read pointer.
module spill_rec_fifo
    import spill_pkg::*;
#(
    parameter int DEPTH = DEF_REC_DEPTH,
    parameter int WID_W = 5,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  rec_t                 push_rec_i,
    input  logic                 pop_i,
    input  logic                 search_valid_i,
    input  logic [WID_W-1:0]     search_wid_i,
    output logic                 found_o,
    output logic [REC_N_W-1:0]   head_n_o,
    output logic [REC_PAD_W-1:0] head_pad_o,
    output logic                 head_done_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [CNT_W-1:0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] sel_off;
    logic             found;

    // match[k] refers to the k-th oldest live record, so the lowest set bit is the oldest hit.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            logic [PTR_W-1:0] idx;
            assign idx = rd_ptr_q + PTR_W'(gi);
            assign match[gi] = (CNT_W'(gi) < count_q)
                             && (mem_q[idx].wid == REC_WID_W'(search_wid_i))
                             && !mem_q[idx].done;
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        sel_off = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                found   = 1'b1;
                sel_off = PTR_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_rec_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (search_valid_i && found) begin
                mem_q[rd_ptr_q + sel_off].done <= 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign found_o     = search_valid_i && found;
    assign head_n_o    = mem_q[rd_ptr_q].n;
    assign head_pad_o  = mem_q[rd_ptr_q].pad;
    assign head_done_o = mem_q[rd_ptr_q].done;
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign count_o     = count_q;

endmodule

// File: rtl/spill_slot_manager.sv
// Circular LDS spill-slot allocator: contiguous grants padded past the ring end,
// out-of-order frees by warp, in-order reclaim, off-chip answer when LDS is full.
module spill_slot_manager
    import spill_pkg::*;
#(
    parameter int SLOTS     = DEF_SLOTS,
    parameter int MAX_N     = DEF_MAX_N,
    parameter int NWARPS    = DEF_NWARPS,
    parameter int REC_DEPTH = DEF_REC_DEPTH,
    parameter int WID_W     = $clog2(NWARPS),
    parameter int ADDR_W    = $clog2(SLOTS),
    parameter int N_W       = $clog2(MAX_N + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [WID_W-1:0]             alloc_wid,
    input  logic [N_W-1:0]               alloc_n,
    output logic                         resp_valid,
    output logic                         resp_lds,
    output logic                         resp_err,
    output logic [ADDR_W-1:0]            resp_base,
    input  logic                         free_valid,
    input  logic [WID_W-1:0]             free_wid,
    output logic                         free_err,
    output logic [ADDR_W:0]              used_count,
    output logic [$clog2(REC_DEPTH):0]   rec_count,
    output logic [ADDR_W:0]              hwm,
    input  logic                         hwm_clr
);
    localparam int CNT_W = $clog2(REC_DEPTH) + 1;

    logic [ADDR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ADDR_W:0]      used_q, used_d, hwm_q, hwm_d;
    logic                 resp_valid_q, resp_lds_q, resp_err_q, free_err_q;
    logic [ADDR_W-1:0]    resp_base_q, resp_base_d;
    fit_t                 fit;
    logic                 accept, size_err, grant, retire;
    logic                 fifo_full, fifo_empty, head_done, found;
    logic [REC_N_W-1:0]   head_n;
    logic [REC_PAD_W-1:0] head_pad;
    rec_t                 push_rec;
    int unsigned          grant_amt, retire_amt, head_sum, tail_sum;

    always_comb begin
        accept      = alloc_valid && !fifo_full;
        size_err    = (alloc_n == '0) || (32'(alloc_n) > 32'(MAX_N));
        fit         = fit_calc(32'(head_q), 32'(alloc_n), 32'(used_q), 32'(SLOTS));
        grant       = accept && !size_err && fit.fits;
        retire      = !fifo_empty && head_done;
        grant_amt   = grant ? 32'(fit.pad) + 32'(alloc_n) : 32'd0;
        retire_amt  = retire ? 32'(head_pad) + 32'(head_n) : 32'd0;
        head_sum    = 32'(fit.base) + 32'(alloc_n);
        tail_sum    = 32'(tail_q) + retire_amt;
        head_d      = head_q;
        tail_d      = tail_q;
        if (grant) begin
            head_d = ADDR_W'((head_sum >= 32'(SLOTS)) ? head_sum - 32'(SLOTS) : head_sum);
        end
        if (retire) begin
            tail_d = ADDR_W'((tail_sum >= 32'(SLOTS)) ? tail_sum - 32'(SLOTS) : tail_sum);
        end
        // Fit check above used the pre-retire count, so this never exceeds SLOTS.
        used_d      = (ADDR_W+1)'(32'(used_q) + grant_amt - retire_amt);
        hwm_d       = hwm_clr ? used_d : ((used_d > hwm_q) ? used_d : hwm_q);
        resp_base_d = grant ? ADDR_W'(fit.base) : '0;
        push_rec    = '{wid: REC_WID_W'(alloc_wid), n: REC_N_W'(alloc_n), pad: fit.pad, done: 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            used_q       <= '0;
            hwm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_lds_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_base_q  <= '0;
            free_err_q   <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            used_q       <= used_d;
            hwm_q        <= hwm_d;
            resp_valid_q <= accept;
            resp_lds_q   <= grant;
            resp_err_q   <= accept && size_err;
            resp_base_q  <= resp_base_d;
            free_err_q   <= free_valid && !found;
        end
    end

    spill_rec_fifo #(
        .DEPTH (REC_DEPTH),
        .WID_W (WID_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push_i         (grant),
        .push_rec_i     (push_rec),
        .pop_i          (retire),
        .search_valid_i (free_valid),
        .search_wid_i   (free_wid),
        .found_o        (found),
        .head_n_o       (head_n),
        .head_pad_o     (head_pad),
        .head_done_o    (head_done),
        .empty_o        (fifo_empty),
        .full_o         (fifo_full),
        .count_o        (rec_count)
    );

    assign alloc_ready = !fifo_full;
    assign resp_valid  = resp_valid_q;
    assign resp_lds    = resp_lds_q;
    assign resp_err    = resp_err_q;
    assign resp_base   = resp_base_q;
    assign free_err    = free_err_q;
    assign used_count  = used_q;
    assign hwm         = hwm_q;

endmodule
